cobs_decode: RTL and testbench

//   Streaming COBS decoder; inverse of the framework COBS encoder. Consumes 0x00-delimited

---
 rtl/cobs_decode.sv | 170 +++++++++++++++++
 tb/tb_cobs_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cobs_decode.sv
// cobs_decode -- streaming COBS frame decoder.
//
// Takes 0x00-delimited COBS frames one byte at a time and emits the decoded
// payload. The last decoded byte is not known to be last until the delimiter
// (or the end-of-frame hint) arrives, so each decoded byte waits in a one-byte
// pending register. It moves to the registered output stage when the next
// decoded byte or the end of the frame arrives.
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   i_data   in   encoded byte
//   i_valid  in   i_data valid
//   o_ready  out  decoder accepts i_data this cycle
//   i_last   in   upstream end-of-frame hint
//   o_data   out  decoded byte (registered)
//   o_valid  out  o_data valid
//   i_ready  in   downstream accepts o_data
//   o_last   out  o_data is the final byte of its frame
//   o_error  out  one-cycle pulse when a malformed frame is terminated
module cobs_decode #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_last,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic          o_error
);

  typedef enum logic [0:0] {
    ST_CODE = 1'b0,  // next byte is a group code or a delimiter
    ST_DATA = 1'b1   // next byte is a literal data byte of the current group
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          zero_due_q, zero_due_d;
  logic          pend_vld_q, pend_vld_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  // Pending byte already ends its frame (i_last on a producing byte)
  logic          pend_last_q, pend_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  logic          accept;
  logic          out_free;
  logic          produce;
  logic [DW-1:0] prod_byte;
  logic          end_frame;
  logic          move;

  assign out_free = !out_valid_q || i_ready;
  assign o_ready  = out_free;
  assign accept   = i_valid && out_free;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    zero_due_d  = zero_due_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !i_ready;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    produce     = 1'b0;
    prod_byte   = '0;
    end_frame   = 1'b0;

    if (accept) begin
      if (state_q == ST_CODE) begin
        if (i_data == '0) begin
          end_frame  = 1'b1;
          zero_due_d = 1'b0;
        end else begin
          // A code after a short group stands for the zero that group implied
          if (zero_due_q) begin
            produce   = 1'b1;
            prod_byte = '0;
          end
          cnt_d      = i_data - 1'b1;
          zero_due_d = (i_data != '1);
          state_d    = (i_data > 1) ? ST_DATA : ST_CODE;
        end
      end else begin
        if (i_data != '0) begin
          produce   = 1'b1;
          prod_byte = i_data;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == 1) state_d = ST_CODE;
        end else begin
          // Delimiter inside a group: frame truncated
          end_frame  = 1'b1;
          err_d      = 1'b1;
          zero_due_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_CODE;
        end
      end

      // End-of-frame hint without a delimiter: finish the frame as if one
      // followed. A byte produced now is tagged and flushed on its own later.
      if (i_last && (i_data != '0)) begin
        err_d      = 1'b1;
        zero_due_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_CODE;
        if (!produce) end_frame = 1'b1;
      end
    end

    // A tagged pending byte drains by itself once the output stage frees up
    move = pend_vld_q && (produce || end_frame || (pend_last_q && out_free));
    if (move) begin
      out_data_d  = pend_data_q;
      out_valid_d = 1'b1;
      out_last_d  = pend_last_q || end_frame;
      pend_vld_d  = 1'b0;
      pend_last_d = 1'b0;
    end

    if (produce) begin
      pend_vld_d  = 1'b1;
      pend_data_d = prod_byte;
      pend_last_d = i_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CODE;
      cnt_q       <= '0;
      zero_due_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zero_due_q  <= zero_due_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign o_data  = out_data_q;
  assign o_valid = out_valid_q;
  assign o_last  = out_last_q;
  assign o_error = err_q;

endmodule

// File: tb/tb_cobs_decode.sv
module tb_cobs_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_last = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       o_error;

  int n_assert = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int stall_viol = 0;
  int timeouts = 0;
  logic toggle_rdy = 1'b0;
  logic [8:0] got[$];

  cobs_decode #(.DW(8)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_error(o_error)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    i_ready = toggle_rdy ? ~i_ready : 1'b1;
  end

  // Collect output beats and error pulses; watch held data during stalls
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;
  always @(negedge clk) begin
    if (prev_stall && (!o_valid || {o_last, o_data} !== prev_out)) stall_viol++;
    prev_stall = o_valid && !i_ready;
    prev_out   = {o_last, o_data};
    if (o_valid && i_ready) got.push_back({o_last, o_data});
    if (o_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    logic acc = 1'b0;
    i_valid = 1'b1;
    i_data = b;
    i_last = l;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    if (!acc) timeouts++;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[k]) send(s[k], 1'b0);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [8:0] exp[$], input int exp_err);
    int n;
    chk({tag, "_count"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    chk({tag, "_errors"}, err_cnt, exp_err);
    got.delete();
    err_cnt = 0;
  endtask

  initial begin
    logic [7:0] s[$];
    logic [8:0] e[$];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_o_error", o_error, 0);
    chk("rst_o_ready", o_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single group
    s = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h001, 9'h002, 9'h003, 9'h104};
    check_out("t1", e, 0);

    // 2: inserted zero between groups; frame decoding to a lone zero
    s = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h011, 9'h022, 9'h000, 9'h133};
    check_out("t2a", e, 0);
    s = '{8'h01, 8'h01, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h100};
    check_out("t2b", e, 0);

    // 3: maximal group, no zero after it
    s = '{8'hFF};
    e = {};
    for (int v = 1; v <= 254; v++) begin
      s.push_back(8'(v));
      e.push_back(9'(v));
    end
    s.push_back(8'h01);
    s.push_back(8'h00);
    e[253] = 9'h1FE;
    send_seq(s);
    drain();
    check_out("t3", e, 0);

    // 4: backpressure toggling plus input gaps
    toggle_rdy = 1'b1;
    s = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    foreach (s[k]) begin
      send(s[k], 1'b0);
      if (k % 2 == 1) repeat (k) @(posedge clk);
      #1;
    end
    drain();
    toggle_rdy = 1'b0;
    drain();
    e = '{9'h001, 9'h002, 9'h003, 9'h104};
    check_out("t4", e, 0);
    chk("t4_stall_hold", stall_viol, 0);

    // 5: truncated group, then recovery
    s = '{8'h05, 8'h01, 8'h02, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h001, 9'h102};
    check_out("t5a", e, 1);
    s = '{8'h02, 8'hAA, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h1AA};
    check_out("t5b", e, 0);

    // 6: empty frame, then reset mid-frame
    s = '{8'h01, 8'h00};
    send_seq(s);
    drain();
    e = {};
    check_out("t6a", e, 0);
    s = '{8'h04, 8'h01};
    send_seq(s);
    rst = 1'b1;
    #1;
    chk("t6_rst_o_valid", o_valid, 0);
    chk("t6_rst_o_data", o_data, 0);
    chk("t6_rst_o_last", o_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    err_cnt = 0;
    s = '{8'h02, 8'h55, 8'h00};
    send_seq(s);
    drain();
    e = '{9'h155};
    check_out("t6b", e, 0);

    // 7: i_last on a data byte ends the frame with an error
    send(8'h03, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    drain();
    send(8'h00, 1'b0);
    drain();
    e = '{9'h011, 9'h122};
    check_out("t7", e, 1);

    // 8: i_last on the delimiter has no extra effect
    send(8'h02, 1'b0);
    send(8'hAB, 1'b0);
    send(8'h00, 1'b1);
    drain();
    e = '{9'h1AB};
    check_out("t8", e, 0);

    chk("handshake_timeouts", timeouts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
